cnn_inference_sequencer: RTL and testbench

//  Top-level controller for one MNIST inference: conv layer 1 -> conv layer 2 -> MLP -> comparator.

---
 rtl/cnn_pkg.sv | 48 ++++
 rtl/cnn_seq_watchdog.sv | 51 +++++
 rtl/cnn_inference_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_cnn_inference_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared types for the MNIST inference sequencer.
//   seq_state_t : sequencer FSM states
//   stage_t     : pipeline stage identifier, also reported on err_stage
//   stage_of()  : maps a RUN_*/WAIT_* state to the stage it belongs to
//   is_run()    : state issues a run pulse
//   is_wait()   : state waits on a stage done (watchdog armed)
// -----------------------------------------------------------------------------
package cnn_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RUN_C1,
    WAIT_C1,
    RUN_C2,
    WAIT_C2,
    RUN_MLP,
    WAIT_MLP,
    CMP,
    ERR
  } seq_state_t;

  typedef enum logic [1:0] {
    STG_NONE  = 2'd0,
    STG_CONV1 = 2'd1,
    STG_CONV2 = 2'd2,
    STG_MLP   = 2'd3
  } stage_t;

  function automatic stage_t stage_of(input seq_state_t s);
    case (s)
      RUN_C1, WAIT_C1:   return STG_CONV1;
      RUN_C2, WAIT_C2:   return STG_CONV2;
      RUN_MLP, WAIT_MLP: return STG_MLP;
      default:           return STG_NONE;
    endcase
  endfunction

  function automatic logic is_run(input seq_state_t s);
    return s inside {RUN_C1, RUN_C2, RUN_MLP};
  endfunction

  function automatic logic is_wait(input seq_state_t s);
    return s inside {WAIT_C1, WAIT_C2, WAIT_MLP};
  endfunction

endpackage

// File: rtl/cnn_seq_watchdog.sv
// -----------------------------------------------------------------------------
// cnn_seq_watchdog
// Per-stage timeout counter for the inference sequencer.
// Ports:
//   clk       in  system clock
//   reset     in  synchronous active-high reset
//   clear_i   in  restart the count (asserted while a run pulse is issued)
//   enable_i  in  count this cycle (asserted while waiting on a stage done)
//   expired_o out this enabled cycle is the TIMEOUT_CYCLES-th one without done
// The counter saturates at all-ones and never wraps.
// -----------------------------------------------------------------------------
module cnn_seq_watchdog #(
  parameter int TMO_W          = 20,
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  // count_q holds the number of enabled cycles already completed, so the
  // cycle in which it equals TIMEOUT_CYCLES-1 is the last one allowed.
  localparam logic [TMO_W-1:0] LAST_CNT = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: default assignment first so every path drives count_d; no latch.
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all clocked state so every flop
    // samples pre-edge values regardless of process ordering.
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q >= LAST_CNT);

endmodule

// File: rtl/cnn_inference_sequencer.sv
// -----------------------------------------------------------------------------
// cnn_inference_sequencer
// Top-level controller for one MNIST inference:
//   conv1 -> conv2 -> MLP -> comparator.
// A rising edge on the host start level launches one inference; each stage
// receives a single-cycle run pulse and the sequencer waits for its done.
// Host writes into the input image memory are dropped while busy.
// A per-stage watchdog moves the FSM to ERR if a stage never finishes.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             host start level (rising edge requests an inference)
//   host_wen_in       host write enable toward the image memory
//   mem_wen           host_wen_in gated by ~busy (combinational)
//   conv1_run/done    conv layer 1 run pulse / finished
//   conv2_run/done    conv layer 2 run pulse / finished
//   mlp_start/done    MLP run pulse / finished
//   class_in          comparator output
//   class_out         latched classification
//   class_valid       class_out valid, sticky until next accepted start
//   busy              inference in flight
//   error             watchdog fired, sticky until next accepted start
//   err_stage         stage_t of the stage that timed out
//   perf_c1/c2/mlp    per-stage cycle counts (only with CNN_SEQ_PERF_EN)
//
// Optional feature macro: CNN_SEQ_PERF_EN adds the perf_* counters/ports.
// -----------------------------------------------------------------------------
module cnn_inference_sequencer
  import cnn_pkg::*;
#(
  parameter int CLASS_W        = 4,
  parameter int TIMEOUT_CYCLES = 1048575,
  parameter int TMO_W          = 20,
  parameter int CMP_LAT        = 1
`ifdef CNN_SEQ_PERF_EN
  , parameter int PERF_W       = 24
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               host_wen_in,
  output logic               mem_wen,
  output logic               conv1_run,
  input  logic               conv1_done,
  output logic               conv2_run,
  input  logic               conv2_done,
  output logic               mlp_start,
  input  logic               mlp_done,
  input  logic [CLASS_W-1:0] class_in,
  output logic [CLASS_W-1:0] class_out,
  output logic               class_valid,
  output logic               busy,
  output logic               error,
  output logic [1:0]         err_stage
`ifdef CNN_SEQ_PERF_EN
  , output logic [PERF_W-1:0] perf_c1
  , output logic [PERF_W-1:0] perf_c2
  , output logic [PERF_W-1:0] perf_mlp
`endif
);

  localparam int              CMP_W    = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
  localparam logic [CMP_W-1:0] CMP_LAST = CMP_W'(CMP_LAT - 1);

  seq_state_t         state_q, state_d;
  logic               start_q, start_qq;
  logic               rise, accept;
  logic [CMP_W-1:0]   cmp_cnt_q, cmp_cnt_d;
  logic               cmp_last;
  logic               wd_clear, wd_enable, wd_expired;

  logic [CLASS_W-1:0] class_q, class_d;
  logic               class_valid_q, class_valid_d;
  logic               error_q, error_d;
  stage_t             err_stage_q, err_stage_d;

  // Two-flop edge detector on the host start level.
  assign rise   = start_q & ~start_qq;
  // A rise is only honoured when no inference is running; it is not queued.
  assign accept = rise && (state_q == IDLE || state_q == ERR);

  assign cmp_last  = (cmp_cnt_q == CMP_LAST);
  assign cmp_cnt_d = (state_q == CMP) ? cmp_cnt_q + 1'b1 : '0;

  assign wd_clear  = is_run(state_q);
  assign wd_enable = is_wait(state_q);

  cnn_seq_watchdog #(
    .TMO_W          (TMO_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (wd_clear),
    .enable_i  (wd_enable),
    .expired_o (wd_expired)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      start_qq  <= 1'b0;
      cmp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      start_qq  <= start_q;
      cmp_cnt_q <= cmp_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. Done inputs are looked at only in their own WAIT state;
  // done is tested before the watchdog so a same-cycle done wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ERR: if (rise) state_d = RUN_C1;
      RUN_C1:    state_d = WAIT_C1;
      WAIT_C1: begin
        if (conv1_done)      state_d = RUN_C2;
        else if (wd_expired) state_d = ERR;
      end
      RUN_C2:    state_d = WAIT_C2;
      WAIT_C2: begin
        if (conv2_done)      state_d = RUN_MLP;
        else if (wd_expired) state_d = ERR;
      end
      RUN_MLP:   state_d = WAIT_MLP;
      WAIT_MLP: begin
        if (mlp_done)        state_d = CMP;
        else if (wd_expired) state_d = ERR;
      end
      CMP:       if (cmp_last) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    conv1_run = (state_q == RUN_C1);
    conv2_run = (state_q == RUN_C2);
    mlp_start = (state_q == RUN_MLP);
    busy      = !(state_q inside {IDLE, ERR});
    mem_wen   = host_wen_in & ~busy;
  end

  // ---------------------------------------------------------------------------
  // Result and error registers
  // ---------------------------------------------------------------------------
  always_comb begin
    class_d       = class_q;
    class_valid_d = class_valid_q;
    error_d       = error_q;
    err_stage_d   = err_stage_q;
    if (accept) begin
      class_valid_d = 1'b0;
      error_d       = 1'b0;
      err_stage_d   = STG_NONE;
    end
    // Comparator output is valid on the last CMP cycle.
    if (state_q == CMP && cmp_last) begin
      class_d       = class_in;
      class_valid_d = 1'b1;
    end
    if (is_wait(state_q) && state_d == ERR) begin
      error_d     = 1'b1;
      err_stage_d = stage_of(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      class_q       <= '0;
      class_valid_q <= 1'b0;
      error_q       <= 1'b0;
      err_stage_q   <= STG_NONE;
    end else begin
      class_q       <= class_d;
      class_valid_q <= class_valid_d;
      error_q       <= error_d;
      err_stage_q   <= err_stage_d;
    end
  end

  assign class_out   = class_q;
  assign class_valid = class_valid_q;
  assign error       = error_q;
  assign err_stage   = err_stage_q;

`ifdef CNN_SEQ_PERF_EN
  // ---------------------------------------------------------------------------
  // Per-stage latency counters: every cycle spent in RUN_x or WAIT_x counts,
  // so the done-accept cycle is included. Saturating, cleared on accept.
  // ---------------------------------------------------------------------------
  logic [PERF_W-1:0] perf_c1_q, perf_c1_d;
  logic [PERF_W-1:0] perf_c2_q, perf_c2_d;
  logic [PERF_W-1:0] perf_mlp_q, perf_mlp_d;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    perf_c1_d  = perf_c1_q;
    perf_c2_d  = perf_c2_q;
    perf_mlp_d = perf_mlp_q;
    if (accept) begin
      perf_c1_d  = '0;
      perf_c2_d  = '0;
      perf_mlp_d = '0;
    end else begin
      unique case (stage_of(state_q))
        STG_CONV1: perf_c1_d  = sat_inc(perf_c1_q);
        STG_CONV2: perf_c2_d  = sat_inc(perf_c2_q);
        STG_MLP:   perf_mlp_d = sat_inc(perf_mlp_q);
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_c1_q  <= '0;
      perf_c2_q  <= '0;
      perf_mlp_q <= '0;
    end else begin
      perf_c1_q  <= perf_c1_d;
      perf_c2_q  <= perf_c2_d;
      perf_mlp_q <= perf_mlp_d;
    end
  end

  assign perf_c1  = perf_c1_q;
  assign perf_c2  = perf_c2_q;
  assign perf_mlp = perf_mlp_q;
`endif

endmodule

// File: tb/tb_cnn_inference_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cnn_inference_sequencer
// Directed bench for cnn_inference_sequencer. Stimulus pushes the expected
// run pulses / classification / error events into a queue; a monitor pops
// and compares each event as the DUT presents it. Inline checks cover reset
// state, write gating, CMP timing, stickiness and the watchdog window.
// -----------------------------------------------------------------------------
module tb_cnn_inference_sequencer;

  typedef enum int {EV_C1, EV_C2, EV_MLP, EV_CLASS, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       val;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       host_wen_in = 1'b0;
  logic       mem_wen;
  logic       conv1_run, conv2_run, mlp_start;
  logic       conv1_done = 1'b0, conv2_done = 1'b0, mlp_done = 1'b0;
  logic [3:0] class_in = 4'd0;
  logic [3:0] class_out;
  logic       class_valid, busy, error;
  logic [1:0] err_stage;
`ifdef CNN_SEQ_PERF_EN
  logic [23:0] perf_c1, perf_c2, perf_mlp;
`endif

  int  n_checks = 0;
  int  n_errors = 0;
  ev_t sb_q[$];
  bit  cv_prev = 1'b0;
  bit  err_prev = 1'b0;

  cnn_inference_sequencer #(
    .CLASS_W        (4),
    .TIMEOUT_CYCLES (16),
    .TMO_W          (5),
    .CMP_LAT        (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .host_wen_in (host_wen_in),
    .mem_wen     (mem_wen),
    .conv1_run   (conv1_run),
    .conv1_done  (conv1_done),
    .conv2_run   (conv2_run),
    .conv2_done  (conv2_done),
    .mlp_start   (mlp_start),
    .mlp_done    (mlp_done),
    .class_in    (class_in),
    .class_out   (class_out),
    .class_valid (class_valid),
    .busy        (busy),
    .error       (error),
    .err_stage   (err_stage)
`ifdef CNN_SEQ_PERF_EN
    , .perf_c1   (perf_c1)
    , .perf_c2   (perf_c2)
    , .perf_mlp  (perf_mlp)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input int v);
    ev_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_unexpected: got event %s val %0d, expected no event (t=%0t)",
               k.name(), v, $time);
    end else begin
      e = sb_q.pop_front();
      check({"sb_kind_", e.kind.name()}, k, e.kind);
      check({"sb_val_", e.kind.name()}, v, e.val);
    end
  endtask

  // Monitor: every cycle a run pulse is high, and every rising edge of
  // class_valid / error, is one observed event.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (conv1_run === 1'b1) observe(EV_C1, 0);
      if (conv2_run === 1'b1) observe(EV_C2, 0);
      if (mlp_start === 1'b1) observe(EV_MLP, 0);
      if (class_valid === 1'b1 && !cv_prev) observe(EV_CLASS, int'(class_out));
      if (error === 1'b1 && !err_prev) observe(EV_ERR, int'(err_stage));
    end
    cv_prev  = (class_valid === 1'b1);
    err_prev = (error === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_sig(input int which, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      case (which)
        0:       seen = (conv1_run === 1'b1);
        1:       seen = (conv2_run === 1'b1);
        default: seen = (mlp_start === 1'b1);
      endcase
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_run%0d: got no run pulse in 50 cycles, expected one", which);
    end
  endtask

  // Assert the done of stage 'which' for one cycle, 'lat' cycles after now.
  task automatic drive_done(input int which, input int lat, input int cls);
    repeat (lat) @(posedge clk);
    #1;
    case (which)
      0: begin conv1_done = 1'b1; expect_ev(EV_C2, 0); end
      1: begin conv2_done = 1'b1; expect_ev(EV_MLP, 0); end
      default: begin
        mlp_done = 1'b1;
        class_in = 4'(cls);
        expect_ev(EV_CLASS, cls);
      end
    endcase
    tick();
    conv1_done = 1'b0;
    conv2_done = 1'b0;
    mlp_done   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_c1run"}, conv1_run, 0);
    check({tag, "_c2run"}, conv2_run, 0);
    check({tag, "_mlpst"}, mlp_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_errstg"}, err_stage, 0);
    check({tag, "_cvalid"}, class_valid, 0);
    check({tag, "_class"}, class_out, 0);
    check({tag, "_memwen"}, mem_wen, 0);
  endtask

  // One full inference with host_wen_in held high. With 'spurious' set,
  // stray dones and a second start rise are injected around WAIT_C1.
  task automatic run_inference(input int l1, input int l2, input int l3,
                               input int cls, input bit spurious);
    bit seen;
    expect_ev(EV_C1, 0);
    pulse_start();
    wait_sig(0, seen);
    check("run_c1_busy", busy, 1);
    check("run_c1_memwen", mem_wen, 0);
    check("run_c1_err_clr", error, 0);
    check("run_c1_cv_clr", class_valid, 0);
    if (spurious) begin
      conv1_done = 1'b1;          // coincident with the conv1_run pulse
      tick();
      conv1_done = 1'b0;
      conv2_done = 1'b1;          // wrong stage's done during WAIT_C1
      mlp_done   = 1'b1;
      start      = 1'b1;          // second rise while busy
      tick();
      conv2_done = 1'b0;
      mlp_done   = 1'b0;
      tick();
      start      = 1'b0;
      repeat (4) tick();
      @(negedge clk);
      check("spur_busy", busy, 1);
      check("spur_memwen", mem_wen, 0);
    end
    drive_done(0, l1, 0);
    wait_sig(1, seen);
    check("run_c2_memwen", mem_wen, 0);
    drive_done(1, l2, 0);
    wait_sig(2, seen);
    check("run_mlp_memwen", mem_wen, 0);
    drive_done(2, l3, cls);
    @(negedge clk);               // CMP cycle
    check("cmp_cvalid", class_valid, 0);
    check("cmp_busy", busy, 1);
    check("cmp_memwen", mem_wen, 0);
    @(negedge clk);               // CMP_LAT+1 cycles after mlp_done
    check("done_cvalid", class_valid, 1);
    check("done_class", class_out, 32'(cls));
    check("done_busy", busy, 0);
    check("done_memwen", mem_wen, 1);
    repeat (6) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_cvalid_sticky", class_valid, 1);
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bit seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("rst");
    host_wen_in = 1'b1;
    @(negedge clk);
    check("idle_memwen", mem_wen, 1);

    // Happy path: 10/7/5 latencies, class 7
    run_inference(10, 7, 5, 7, 1'b0);
`ifdef CNN_SEQ_PERF_EN
    check("perf_c1", perf_c1, 11);
    check("perf_c2", perf_c2, 8);
    check("perf_mlp", perf_mlp, 6);
`endif

    // Timeout in WAIT_C2
    expect_ev(EV_C1, 0);
    pulse_start();
    wait_sig(0, seen);
    drive_done(0, 3, 0);
    wait_sig(1, seen);
    repeat (16) @(negedge clk);   // 16th WAIT_C2 cycle
    check("tmo_not_yet", error, 0);
    check("tmo_busy_wait", busy, 1);
    expect_ev(EV_ERR, 2);
    @(negedge clk);
    check("tmo_error", error, 1);
    check("tmo_stage", err_stage, 2);
    check("tmo_busy", busy, 0);
    check("tmo_memwen", mem_wen, 1);
    repeat (3) @(negedge clk);
    check("tmo_sticky", error, 1);

    // Restart out of ERR
    run_inference(2, 2, 2, 3, 1'b0);
    check("restart_errstg", err_stage, 0);

    // Spurious dones and an overlapping start rise
    check("pre_spur_cvalid", class_valid, 1);
    check("pre_spur_class", class_out, 3);
    run_inference(4, 3, 2, 5, 1'b1);

    // Reset while in WAIT_MLP
    expect_ev(EV_C1, 0);
    pulse_start();
    wait_sig(0, seen);
    drive_done(0, 2, 0);
    wait_sig(1, seen);
    drive_done(1, 2, 0);
    wait_sig(2, seen);
    host_wen_in = 1'b0;
    tick();                       // now in WAIT_MLP
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    mlp_done = 1'b1;              // late done, must be ignored
    class_in = 4'd9;
    tick();
    mlp_done = 1'b0;
    repeat (6) @(negedge clk);
    check("late_done_busy", busy, 0);
    check("late_done_cvalid", class_valid, 0);
    check("late_done_class", class_out, 0);
    host_wen_in = 1'b1;
    @(negedge clk);
    check("post_rst_memwen", mem_wen, 1);

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
